// File: rtl/hazard_scoreboard_control_unit_pkg.sv
// Shared constants for the hazard/scoreboard control unit.
// Holds opcode encodings, bypass select encodings and width helpers.
package hazard_scoreboard_control_unit_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

  localparam int unsigned BYP_REGFILE = 0;

  // Width of a bypass select covering regfile, every stage and the ll port.
  function automatic int unsigned byp_w(input int unsigned num_stages);
    return $clog2(num_stages + 2);
  endfunction

  // Select value for the long-latency completion port.
  function automatic int unsigned byp_ll(input int unsigned num_stages);
    return num_stages + 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_control_unit_reg_scoreboard.sv
// Pending-write scoreboard for long-latency register writes.
// Ports: clock/reset (async active-low), issue/issue_rd set a pending bit,
// complete/complete_rd clear one, three lookup ports (rd_addr*/hit*_c),
// outstanding count and full_c flag.
module reg_scoreboard
  import hazard_scoreboard_control_unit_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             complete,
  input  logic [REG_W-1:0] complete_rd,
  input  logic [REG_W-1:0] rd_addr0,
  input  logic [REG_W-1:0] rd_addr1,
  input  logic [REG_W-1:0] rd_addr2,
  output logic             hit0_c,
  output logic             hit1_c,
  output logic             hit2_c,
  output logic [OUT_W-1:0] outstanding,
  output logic             full_c
);

  logic [31:1]      pending;
  logic [31:0]      pend_vec;
  logic [31:0]      vec_next;
  logic             clr_ok;
  logic             set_ok;
  logic [OUT_W-1:0] cnt_next;

  assign pend_vec = {pending, 1'b0};
  assign hit0_c   = pend_vec[rd_addr0];
  assign hit1_c   = pend_vec[rd_addr1];
  assign hit2_c   = pend_vec[rd_addr2];
  assign full_c   = (outstanding == OUT_W'(MAX_OUTSTANDING));

  // Clear before set; a completion without a pending bit is ignored.
  always_comb begin
    vec_next = pend_vec;
    clr_ok   = complete & pend_vec[complete_rd];
    if (clr_ok) vec_next[complete_rd] = 1'b0;
    set_ok   = issue & (issue_rd != '0) & !vec_next[issue_rd];
    if (issue && issue_rd != '0) vec_next[issue_rd] = 1'b1;
    cnt_next = outstanding + OUT_W'(set_ok) - OUT_W'(clr_ok);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending     <= '0;
      outstanding <= '0;
    end else begin
      pending     <= vec_next[31:1];
      outstanding <= cnt_next;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_control_unit.sv
// Decode-stage hazard unit: stage forwarding selects, load-use and
// scoreboard stalls, and a saturating stall-cycle counter.
// Ports: clock/reset (async active-low); decode operands rs1/rs2 with
// qualifiers, rd_decode/regwrite_decode; packed per-stage rd/regwrite/opcode;
// long-latency issue/complete; stall_ext, perf_clear. Outputs are the rs1/rs2
// mux selects, global stall, outstanding count and stall_cycles.
module hazard_scoreboard_control_unit
  import hazard_scoreboard_control_unit_pkg::*;
#(
  parameter int unsigned NUM_STAGES      = 4,
  parameter int unsigned LOAD_DATA_STAGE = 3,
  parameter int unsigned BYPASS_EN       = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 32,
  localparam int unsigned BYP_W = byp_w(NUM_STAGES),
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [REG_W-1:0]            rs1,
  input  logic [REG_W-1:0]            rs2,
  input  logic                        rs1_used,
  input  logic                        rs2_used,
  input  logic [REG_W-1:0]            rd_decode,
  input  logic                        regwrite_decode,
  input  logic [REG_W*NUM_STAGES-1:0] rd_stage,
  input  logic [NUM_STAGES-1:0]       regwrite_stage,
  input  logic [OPC_W*NUM_STAGES-1:0] opcode_stage,
  input  logic                        ll_issue,
  input  logic                        ll_complete,
  input  logic [REG_W-1:0]            ll_complete_rd,
  input  logic                        stall_ext,
  input  logic                        perf_clear,
  output logic [BYP_W-1:0]            rs1_data_bypass,
  output logic [BYP_W-1:0]            rs2_data_bypass,
  output logic                        stall,
  output logic [OUT_W-1:0]            outstanding,
  output logic [CNT_W-1:0]            stall_cycles
);

  logic [NUM_STAGES-1:0] hz1, hz2, early_load;
  logic load_stall, raw_stall, sb_stall, full;
  logic p1, p2, p3;
  logic cmp1, cmp2, cmp3;
  logic ll_hit1, ll_hit2;

  // Youngest (lowest index) matching stage wins; ll port overrides stages.
  function automatic logic [BYP_W-1:0] pick(input logic [NUM_STAGES-1:0] hz,
                                            input logic ll_hit);
    logic [BYP_W-1:0] sel;
    sel = BYP_W'(BYP_REGFILE);
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--)
      if (hz[i]) sel = BYP_W'(i + 1);
    if (ll_hit) sel = BYP_W'(byp_ll(NUM_STAGES));
    return sel;
  endfunction

  // Per-stage RAW compare and early-load detection.
  always_comb begin
    hz1        = '0;
    hz2        = '0;
    early_load = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      hz1[i] = rs1_used & regwrite_stage[i] & (rs1 == rd_stage[i*REG_W +: REG_W]) & (rs1 != '0);
      hz2[i] = rs2_used & regwrite_stage[i] & (rs2 == rd_stage[i*REG_W +: REG_W]) & (rs2 != '0);
      early_load[i] = (opcode_stage[i*OPC_W +: OPC_W] == OP_LOAD) && (i < LOAD_DATA_STAGE);
    end
  end

  assign cmp1 = ll_complete & (ll_complete_rd == rs1);
  assign cmp2 = ll_complete & (ll_complete_rd == rs2);
  assign cmp3 = ll_complete & (ll_complete_rd == rd_decode);

  assign load_stall = |((hz1 | hz2) & early_load);
  assign raw_stall  = (BYPASS_EN != 0) ? load_stall : |(hz1 | hz2);
  // A completing register no longer blocks: its value comes from the ll port.
  assign sb_stall   = (rs1_used & p1 & !cmp1) | (rs2_used & p2 & !cmp2) |
                      (regwrite_decode & p3 & !cmp3) | (ll_issue & full);

  assign ll_hit1 = rs1_used & (rs1 != '0) & cmp1;
  assign ll_hit2 = rs2_used & (rs2 != '0) & cmp2;

  always_comb begin
    stall           = raw_stall | sb_stall | stall_ext;
    rs1_data_bypass = BYP_W'(BYP_REGFILE);
    rs2_data_bypass = BYP_W'(BYP_REGFILE);
    if (!stall && BYPASS_EN != 0) begin
      rs1_data_bypass = pick(hz1, ll_hit1);
      rs2_data_bypass = pick(hz2, ll_hit2);
    end
  end

  reg_scoreboard #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_sb (
    .clock       (clock),
    .reset       (reset),
    .issue       (ll_issue & !stall),
    .issue_rd    (rd_decode),
    .complete    (ll_complete),
    .complete_rd (ll_complete_rd),
    .rd_addr0    (rs1),
    .rd_addr1    (rs2),
    .rd_addr2    (rd_decode),
    .hit0_c      (p1),
    .hit1_c      (p2),
    .hit2_c      (p3),
    .outstanding (outstanding),
    .full_c      (full)
  );

  // Saturating stall-cycle counter; clear has priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_cycles <= '0;
    else if (perf_clear)
      stall_cycles <= '0;
    else if (stall && !(&stall_cycles))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard_control_unit.sv
// Self-checking bench: default config, a no-bypass instance and a 4-bit
// counter instance share the same stimulus.
module tb_hazard_scoreboard_control_unit;
  import hazard_scoreboard_control_unit_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic [4:0] rs1, rs2, rd_decode, ll_complete_rd;
  logic rs1_used, rs2_used, regwrite_decode, ll_issue, ll_complete, stall_ext, perf_clear;
  logic [19:0] rd_stage;
  logic [3:0]  regwrite_stage;
  logic [27:0] opcode_stage;

  logic [2:0] b1_main, b2_main, outs_main, b1_nb, b2_nb, outs_nb, b1_c4, b2_c4, outs_c4;
  logic stall_main, stall_nb, stall_c4;
  logic [31:0] cnt_main, cnt_nb;
  logic [3:0]  cnt_c4;

  always #5 clock = ~clock;

  hazard_scoreboard_control_unit u_main (
    .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_decode(rd_decode), .regwrite_decode(regwrite_decode), .rd_stage(rd_stage),
    .regwrite_stage(regwrite_stage), .opcode_stage(opcode_stage), .ll_issue(ll_issue),
    .ll_complete(ll_complete), .ll_complete_rd(ll_complete_rd), .stall_ext(stall_ext),
    .perf_clear(perf_clear), .rs1_data_bypass(b1_main), .rs2_data_bypass(b2_main),
    .stall(stall_main), .outstanding(outs_main), .stall_cycles(cnt_main));

  hazard_scoreboard_control_unit #(.BYPASS_EN(0)) u_nb (
    .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_decode(rd_decode), .regwrite_decode(regwrite_decode), .rd_stage(rd_stage),
    .regwrite_stage(regwrite_stage), .opcode_stage(opcode_stage), .ll_issue(ll_issue),
    .ll_complete(ll_complete), .ll_complete_rd(ll_complete_rd), .stall_ext(stall_ext),
    .perf_clear(perf_clear), .rs1_data_bypass(b1_nb), .rs2_data_bypass(b2_nb),
    .stall(stall_nb), .outstanding(outs_nb), .stall_cycles(cnt_nb));

  hazard_scoreboard_control_unit #(.CNT_W(4)) u_c4 (
    .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_decode(rd_decode), .regwrite_decode(regwrite_decode), .rd_stage(rd_stage),
    .regwrite_stage(regwrite_stage), .opcode_stage(opcode_stage), .ll_issue(ll_issue),
    .ll_complete(ll_complete), .ll_complete_rd(ll_complete_rd), .stall_ext(stall_ext),
    .perf_clear(perf_clear), .rs1_data_bypass(b1_c4), .rs2_data_bypass(b2_c4),
    .stall(stall_c4), .outstanding(outs_c4), .stall_cycles(cnt_c4));

  localparam int K_STALL = 0, K_B1 = 1, K_B2 = 2, K_OUT = 3, K_NB_STALL = 4,
                 K_NB_B1 = 5, K_CNT = 6, K_CNT4 = 7;

  typedef struct {
    string            name;
    int               kind;
    longint unsigned  exp;
  } exp_t;

  typedef struct {
    logic [4:0]  r1, r2;
    logic        u1, u2;
    logic [19:0] rds;
    logic [3:0]  we;
    logic [27:0] ops;
    logic        e_stall;
    logic [2:0]  e_b1, e_b2;
    logic        e_nb_stall;
  } vec_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [19:0] rd4(input logic [4:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [27:0] op4(input logic [6:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  function automatic longint unsigned actual(input int k);
    case (k)
      K_STALL:    return longint'(stall_main);
      K_B1:       return longint'(b1_main);
      K_B2:       return longint'(b2_main);
      K_OUT:      return longint'(outs_main);
      K_NB_STALL: return longint'(stall_nb);
      K_NB_B1:    return longint'(b1_nb);
      K_CNT:      return longint'(cnt_main);
      default:    return longint'(cnt_c4);
    endcase
  endfunction

  task automatic cmp(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input string name, input int kind, input longint unsigned exp);
    exp_t e;
    e.name = name; e.kind = kind; e.exp = exp;
    q.push_back(e);
  endtask

  // Expected values queued during a cycle are compared mid-cycle.
  always @(negedge clock) begin : popper
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      cmp(e.name, actual(e.kind), e.exp);
    end
  end

  // Outstanding must never exceed the configured maximum (e.g. via underflow wrap).
  always @(negedge clock) begin
    assert (!(reset === 1'b1 && outs_main > 3'd4))
    else begin
      n_fail++;
      $display("FAIL outstanding_range: got %0d expected <= 4", outs_main);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; rs1_used = 0; rs2_used = 0; rd_decode = '0; regwrite_decode = 0;
    rd_stage = '0; regwrite_stage = '0; opcode_stage = op4(OP_REG, OP_REG, OP_REG, OP_REG);
    ll_issue = 0; ll_complete = 0; ll_complete_rd = '0; stall_ext = 0; perf_clear = 0;
  endtask

  task automatic issue(input logic [4:0] r);
    ll_issue = 1; rd_decode = r; regwrite_decode = 1;
  endtask

  task automatic complete(input logic [4:0] r);
    ll_complete = 1; ll_complete_rd = r;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[13];
    logic [6:0] A, L;
    A = OP_REG; L = OP_LOAD;
    //            r1 r2 u1 u2 rds                we       ops               st b1 b2 nb
    vecs[0]  = '{5, 0, 1, 0, rd4(5, 0, 0, 0), 4'b0001, op4(A, A, A, A), 0, 1, 0, 1};
    vecs[1]  = '{5, 0, 1, 0, rd4(5, 0, 5, 0), 4'b0101, op4(A, A, A, A), 0, 1, 0, 1};
    vecs[2]  = '{5, 0, 1, 0, rd4(0, 0, 5, 0), 4'b0100, op4(A, A, A, A), 0, 3, 0, 1};
    vecs[3]  = '{0, 7, 0, 1, rd4(7, 0, 0, 0), 4'b0001, op4(L, A, A, A), 1, 0, 0, 1};
    vecs[4]  = '{0, 7, 0, 1, rd4(0, 0, 0, 7), 4'b1000, op4(A, A, A, L), 0, 0, 4, 1};
    vecs[5]  = '{0, 7, 0, 1, rd4(0, 0, 7, 0), 4'b0100, op4(A, A, L, A), 1, 0, 0, 1};
    vecs[6]  = '{0, 0, 1, 1, rd4(0, 0, 0, 0), 4'b1111, op4(L, L, L, L), 0, 0, 0, 0};
    vecs[7]  = '{3, 0, 1, 0, rd4(0, 0, 3, 0), 4'b0100, op4(A, A, A, A), 0, 3, 0, 1};
    vecs[8]  = '{5, 6, 1, 1, rd4(0, 6, 0, 5), 4'b1010, op4(A, A, A, A), 0, 4, 2, 1};
    vecs[9]  = '{5, 0, 1, 0, rd4(5, 5, 5, 5), 4'b0000, op4(A, A, A, A), 0, 0, 0, 0};
    vecs[10] = '{5, 0, 0, 0, rd4(5, 0, 0, 0), 4'b0001, op4(A, A, A, A), 0, 0, 0, 0};
    vecs[11] = '{5, 7, 1, 1, rd4(5, 7, 0, 0), 4'b0011, op4(A, L, A, A), 1, 0, 0, 1};
    vecs[12] = '{0, 7, 0, 1, rd4(7, 0, 0, 0), 4'b0001, op4(OP_STORE, A, A, A), 0, 0, 1, 1};

    reset = 0;
    idle();
    tick();
    push("rst_outstanding", K_OUT, 0);
    push("rst_stall_cycles", K_CNT, 0);
    push("rst_stall", K_STALL, 0);
    tick();
    reset = 1;
    push("post_rst_outstanding", K_OUT, 0);

    // Stage forwarding / load-use table.
    for (int i = 0; i < 13; i++) begin
      tick();
      idle();
      rs1 = vecs[i].r1; rs2 = vecs[i].r2; rs1_used = vecs[i].u1; rs2_used = vecs[i].u2;
      rd_stage = vecs[i].rds; regwrite_stage = vecs[i].we; opcode_stage = vecs[i].ops;
      push($sformatf("vec%0d_stall", i), K_STALL, longint'(vecs[i].e_stall));
      push($sformatf("vec%0d_b1", i), K_B1, longint'(vecs[i].e_b1));
      push($sformatf("vec%0d_b2", i), K_B2, longint'(vecs[i].e_b2));
      push($sformatf("vec%0d_nb_stall", i), K_NB_STALL, longint'(vecs[i].e_nb_stall));
      push($sformatf("vec%0d_nb_b1", i), K_NB_B1, 0);
    end

    // Issue x9, use it, then complete it with bypass from the ll port.
    tick(); idle(); issue(9);
    push("sbA_issue_stall", K_STALL, 0);
    tick(); idle(); rs1 = 9; rs1_used = 1;
    push("sbA_use_stall", K_STALL, 1);
    push("sbA_use_b1", K_B1, 0);
    push("sbA_outstanding", K_OUT, 1);
    tick(); idle(); rs1 = 9; rs1_used = 1; complete(9);
    push("sbA_cmp_stall", K_STALL, 0);
    push("sbA_cmp_b1", K_B1, 5);
    tick(); idle();
    push("sbA_drained", K_OUT, 0);

    // Fill to MAX_OUTSTANDING, fifth issue waits for a completion.
    for (int r = 1; r <= 4; r++) begin
      tick(); idle(); issue(5'(r));
      push($sformatf("sbB_issue%0d_stall", r), K_STALL, 0);
      push($sformatf("sbB_issue%0d_out", r), K_OUT, longint'(r - 1));
    end
    tick(); idle(); issue(10);
    push("sbB_full_out", K_OUT, 4);
    push("sbB_full_stall", K_STALL, 1);
    tick(); idle(); issue(10); complete(1);
    push("sbB_full_cmp_stall", K_STALL, 1);
    tick(); idle(); issue(10);
    push("sbB_after_cmp_out", K_OUT, 3);
    push("sbB_after_cmp_stall", K_STALL, 0);
    tick(); idle();
    push("sbB_refill_out", K_OUT, 4);
    foreach (vecs[k]) begin end
    tick(); idle(); complete(2);
    tick(); idle(); complete(3);
    tick(); idle(); complete(4);
    tick(); idle(); complete(10);
    tick(); idle();
    push("sbB_drained", K_OUT, 0);

    // Simultaneous complete and re-issue of x9.
    tick(); idle(); issue(9);
    tick(); idle(); issue(9); complete(9);
    push("sbC_same_stall", K_STALL, 0);
    push("sbC_same_out", K_OUT, 1);
    tick(); idle(); rs1 = 9; rs1_used = 1;
    push("sbC_pending9_stall", K_STALL, 1);
    push("sbC_out_unchanged", K_OUT, 1);
    tick(); idle(); complete(9);
    tick(); idle();
    push("sbC_drained", K_OUT, 0);

    // Spurious completion and WAW.
    tick(); idle(); complete(12);
    tick(); idle();
    push("sbD_spurious_empty", K_OUT, 0);
    tick(); idle(); issue(9);
    tick(); idle(); rd_decode = 9; regwrite_decode = 1;
    push("sbD_waw_stall", K_STALL, 1);
    tick(); idle(); complete(12);
    tick(); idle();
    push("sbD_spurious_keep", K_OUT, 1);
    tick(); idle(); complete(9);
    tick(); idle();
    push("sbD_drained", K_OUT, 0);

    // Stall-cycle counter, saturation and clear.
    tick(); idle(); perf_clear = 1;
    for (int c = 0; c < 10; c++) begin
      tick(); idle(); stall_ext = 1;
      if (c == 0) push("cnt_ext_stall", K_STALL, 1);
    end
    tick(); idle();
    push("cnt_10", K_CNT, 10);
    push("cnt4_10", K_CNT4, 10);
    for (int c = 0; c < 10; c++) begin
      tick(); idle(); stall_ext = 1;
    end
    tick(); idle();
    push("cnt_20", K_CNT, 20);
    push("cnt4_sat", K_CNT4, 15);
    tick(); idle(); perf_clear = 1; stall_ext = 1;
    tick(); idle();
    push("cnt_clear", K_CNT, 0);
    push("cnt4_clear", K_CNT4, 0);

    // Asynchronous reset with two entries pending.
    tick(); idle(); issue(1);
    tick(); idle(); issue(2);
    tick(); idle();
    push("rst_pre_out", K_OUT, 2);
    @(negedge clock);
    #2;
    reset = 0;
    #1;
    cmp("rst_async_out", longint'(outs_main), 0);
    tick();
    reset = 1; idle(); rs1 = 1; rs1_used = 1;
    push("rst_pending_gone", K_STALL, 0);
    push("rst_out_after", K_OUT, 0);

    tick(); idle();
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
